fetch_unit_v: RTL

Instruction fetch stage that owns the program counter, drives the synchronous instruction ROM's word address, and presents fetched instructions to decode through a registered IF/ID output with a valid/ready handshake. It absorbs the ROM's one-cycle read latency, holds instructions under decode backpressure by replaying the ROM address, and flushes wrong-path work on a redirect from the branch/jump resolution logic.

---
 rtl/fetch_unit_v_if.sv | 63 ++++++
 rtl/fetch_unit_v.sv | 96 +++++++++
 2 files changed

// File: rtl/fetch_unit_v_if.sv
// Fetch-stage bus: ROM address/data, redirect request and the IF/ID valid/ready output.
// fetch_misaligned exists only when FETCH_MISALIGN_EN is defined.
interface fetch_unit_v_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_instr;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              id_ready;
    logic              out_valid;
    logic [31:0]       out_pc;
    logic [31:0]       out_instr;
`ifdef FETCH_MISALIGN_EN
    logic              fetch_misaligned;

    modport master (
        output rom_addr,
        input  rom_instr,
        input  redirect_valid,
        input  redirect_pc,
        input  id_ready,
        output out_valid,
        output out_pc,
        output out_instr,
        output fetch_misaligned
    );

    modport slave (
        input  rom_addr,
        output rom_instr,
        output redirect_valid,
        output redirect_pc,
        output id_ready,
        input  out_valid,
        input  out_pc,
        input  out_instr,
        input  fetch_misaligned
    );
`else
    modport master (
        output rom_addr,
        input  rom_instr,
        input  redirect_valid,
        input  redirect_pc,
        input  id_ready,
        output out_valid,
        output out_pc,
        output out_instr
    );

    modport slave (
        input  rom_addr,
        output rom_instr,
        output redirect_valid,
        output redirect_pc,
        output id_ready,
        input  out_valid,
        input  out_pc,
        input  out_instr
    );
`endif
endinterface

// File: rtl/fetch_unit_v.sv
// Instruction fetch: owns the PC, drives the synchronous ROM and registers IF/ID output.
// Define FETCH_MISALIGN_EN to flag misaligned redirects and halt fetch until reset.
module fetch_unit_v #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input logic            clk,
    input logic            rst,
    fetch_unit_v_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] pc_req;
    logic [31:0] pc_f;
    logic        f_valid;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_load;
    logic        adv;
    logic        flush;
    logic        halted;
    logic [31:0] redirect_target;

`ifdef FETCH_MISALIGN_EN
    typedef enum logic {
        RUN,
        HALT
    } mode_e;

    mode_e mode;
    mode_e mode_next;
    logic  misaligned_redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode <= RUN;
        end else begin
            mode <= mode_next;
        end
    end

    always_comb begin
        mode_next           = mode;
        misaligned_redirect = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
        if (mode == RUN && misaligned_redirect) begin
            mode_next = HALT;
        end
    end

    assign halted               = (mode == HALT);
    assign bus.fetch_misaligned = halted;
`else
    assign halted = 1'b0;
`endif

    assign flush           = bus.redirect_valid && !halted;
    assign redirect_target = bus.redirect_pc & ~32'h3;
    assign out_load        = f_valid && (!out_valid || bus.id_ready);
    assign adv             = !f_valid || out_load;

    // Without advancing, re-issue the pending address so rom_instr stays valid next cycle.
    assign bus.rom_addr = adv ? pc_req[ADDR_W+1:2] : pc_f[ADDR_W+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_req    <= RESET_PC;
            pc_f      <= '0;
            f_valid   <= 1'b0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= NOP;
        end else if (flush) begin
            pc_req    <= redirect_target;
            f_valid   <= 1'b0;
            out_valid <= 1'b0;
        end else if (!halted) begin
            if (out_load) begin
                out_pc    <= pc_f;
                out_instr <= bus.rom_instr;
                out_valid <= 1'b1;
            end else if (out_valid && bus.id_ready && !f_valid) begin
                out_valid <= 1'b0;
            end
            if (adv) begin
                pc_f    <= pc_req;
                f_valid <= 1'b1;
                pc_req  <= pc_req + 32'd4;
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_pc    = out_pc;
    assign bus.out_instr = out_instr;
endmodule
